seq_hit_logger: RTL and testbench
=================================

# seq_hit_logger

Timestamping event logger that sits directly downstream of the serial pattern detectors (e.g. the overlapping Mealy 11011 detector). It consumes the detector's registered one-cycle match pulse and records the free-running cycle timestamp of every match in a small FIFO. It also keeps a saturating match count and a sticky overflow flag. A host or debug port drains the FIFO through a simple read strobe.

## Interface
- TS_W, default 16: timestamp counter and FIFO data width.
- DEPTH, default 8: FIFO entries; must be a power of two, at least 2.
- AW, default 3: log2(DEPTH); pointer width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- hit  in  1  match pulse from the detector's registered out; may be high on any number of consecutive cycles.
- clr  in  1  synchronous clear of FIFO, hit_count and overflow.
- rd_en  in  1  read strobe; pops one entry when FIFO is not empty.
- rd_data  out  TS_W  popped timestamp, registered.
- rd_valid  out  1  one-cycle pulse qualifying rd_data.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds DEPTH entries.
- level  out  AW+1  current entry count, 0..DEPTH.
- hit_count  out  16  matches seen since reset/clr; saturates at 16'hFFFF.
- overflow  out  1  sticky; set when a hit is dropped because the FIFO is full.

## Operation
- Timestamp counter ts (TS_W bits):
  - Free-running; +1 every cycle; wraps from 2^TS_W-1 to 0.
  - Cleared only by rst, never by clr.
- Write: on an edge with hit=1, the value of ts before that edge's increment is the value written.
  - Accepted if not full, or if full and a read is accepted on the same edge.
- Drop: hit=1 while full with no accepted read.
  - Entry discarded, overflow set to 1.
  - hit_count still increments.
- hit_count increments on every hit=1 edge unless clr=1; holds at 16'hFFFF.
- Read: rd_en=1 and not empty.
  - On that edge, rd_data takes the oldest entry and rd_valid=1 for exactly one cycle.
  - rd_data holds its last value afterwards.
- rd_en=1 while empty: ignored; rd_valid=0; no pointer change.
  - No write-to-read bypass: a hit on the same edge is stored but not returned that cycle.
- Simultaneous read+write:
  - When full, both succeed; level stays DEPTH; overflow unchanged.
  - Otherwise level is unchanged.
- Pointers: AW-bit read/write pointers wrap modulo DEPTH; full/empty are derived from level.
- clr=1 has priority over hit and rd_en:
  - Pointers, level, hit_count and overflow go to 0; rd_valid=0 next cycle.
  - hit and rd_en on that edge are discarded.
  - rd_data is unchanged.

## Timing
- Reset values (async on rst low): ts=0, level=0, empty=1, full=0, rd_valid=0, rd_data=0, hit_count=0, overflow=0, pointers=0.
- Reset mid-operation discards all entries immediately; the FIFO is empty on the first edge after rst returns high.
- Capture latency: hit on edge N makes the entry visible on edge N. empty, level and full reflect it after edge N.
- Read latency: rd_en sampled on edge N gives rd_data/rd_valid valid after edge N, i.e. the same-cycle registered output.
- Throughput: one write and one read per cycle sustained.
- All outputs are registered or decoded from registered level only; no combinational path from any input to any output.

## Test plan
- Reset, then hit=1 on the edge where ts=5; rd_en on ts=9 → rd_data=5, rd_valid=1 for one cycle; empty=1 after.
- hit on ts=3,6,9 (overlapping 11011 spacing), then three reads → rd_data 3,6,9 in order; hit_count=3; level steps 1,2,3 then 2,1,0.
- Ten consecutive hits starting at ts=20 with DEPTH=8, no reads → full=1, level=8, overflow=1, hit_count=10; reads return 20..27.
- Full FIFO, hit and rd_en on the same edge → oldest entry popped, new ts stored, level=8, overflow stays 0.
- TS_W=4: hits at ts=15 and at the following wrapped ts=0 → reads return 15 then 0. Separately, rd_en while empty → rd_valid=0, level=0.
- With level=3 and overflow=1, assert clr together with hit and rd_en → next cycle level=0, empty=1, hit_count=0, overflow=0, rd_valid=0, ts keeps counting. Separately, assert rst mid-stream → all outputs return to reset values immediately.

Source files
------------

// File: rtl/seq_hit_logger.sv
// seq_hit_logger: records the free-running timestamp of each detector match in a FIFO,
// with a saturating match count and a sticky overflow flag.
module seq_hit_logger #(
  parameter int TS_W = 16,
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hit,
  input  logic            clr,
  input  logic            rd_en,
  output logic [TS_W-1:0] rd_data,
  output logic            rd_valid,
  output logic            empty,
  output logic            full,
  output logic [AW:0]     level,
  output logic [15:0]     hit_count,
  output logic            overflow
);
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic            rd_ok, wr_ok;
  assign empty = level == '0;
  assign full  = level == (AW+1)'(DEPTH);
  assign rd_ok = rd_en && !empty;
  // a full FIFO still accepts a hit when a pop frees the slot on the same edge
  assign wr_ok = hit && (!full || rd_ok);
  always_ff @(posedge clk or negedge rst)
    if (!rst) ts <= '0;
    else ts <= ts + 1'b1;
  always_ff @(posedge clk)
    if (wr_ok && !clr) mem[wptr] <= ts;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      hit_count <= '0;
      overflow  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      hit_count <= '0;
      overflow  <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) rd_data <= mem[rptr];
      rptr      <= rd_ok ? rptr + 1'b1 : rptr;
      wptr      <= wr_ok ? wptr + 1'b1 : wptr;
      level     <= level + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      hit_count <= (hit && hit_count != 16'hFFFF) ? hit_count + 16'd1 : hit_count;
      overflow  <= overflow || (hit && !wr_ok);
    end
endmodule

// File: tb/tb_seq_hit_logger.sv
// tb_seq_hit_logger: directed stimulus checked against a queue-based model every cycle,
// plus literal expectations; a TS_W=4 instance covers timestamp wrap.
module tb_seq_hit_logger;
  logic clk = 0;
  logic rst, hit, clr, rd_en, h4, r4, c4;
  logic [15:0] rd_data, hit_count, hc4;
  logic [3:0] level, lv4, d4;
  logic rd_valid, empty, full, overflow, v4, e4, f4, o4;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;

  seq_hit_logger u_dut (.clk(clk), .rst(rst), .hit(hit), .clr(clr), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full), .level(level),
    .hit_count(hit_count), .overflow(overflow));
  seq_hit_logger #(.TS_W(4)) u_w4 (.clk(clk), .rst(rst), .hit(h4), .clr(c4), .rd_en(r4),
    .rd_data(d4), .rd_valid(v4), .empty(e4), .full(f4), .level(lv4),
    .hit_count(hc4), .overflow(o4));

  // model: queue of stored timestamps plus plain counters
  int m_q[$];
  int m_ts = 0, m_cnt = 0, m_rd = 0;
  bit m_rv = 0, m_ovf = 0, m_r, m_was_full;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_q.delete(); m_ts = 0; m_cnt = 0; m_rd = 0; m_rv = 0; m_ovf = 0;
    end else begin
      if (clr) begin
        m_q.delete(); m_cnt = 0; m_ovf = 0; m_rv = 0;
      end else begin
        m_r = rd_en && m_q.size() > 0;
        m_was_full = m_q.size() == 8;
        m_rv = m_r;
        if (m_r) m_rd = m_q.pop_front();
        if (hit) begin
          if (!m_was_full || m_r) m_q.push_back(m_ts);
          else m_ovf = 1;
          if (m_cnt < 65535) m_cnt++;
        end
      end
      m_ts = (m_ts + 1) % 65536;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst === 1'b1) begin
      chk("cyc rd_valid", rd_valid, m_rv);
      chk("cyc rd_data", rd_data, m_rd);
      chk("cyc level", level, m_q.size());
      chk("cyc empty", empty, m_q.size() == 0);
      chk("cyc full", full, m_q.size() == 8);
      chk("cyc hit_count", hit_count, m_cnt);
      chk("cyc overflow", overflow, m_ovf);
    end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic at(input int k);
    for (int i = 0; i < 300 && m_ts != k; i++) @(negedge clk);
    if (m_ts != k) begin
      $display("FAIL wait_ts: got %0d, expected %0d", m_ts, k);
      $fatal(1, "timestamp wait expired");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " level"}, level, 0);
    chk({tag, " empty"}, empty, 1);
    chk({tag, " full"}, full, 0);
    chk({tag, " rd_valid"}, rd_valid, 0);
    chk({tag, " rd_data"}, rd_data, 0);
    chk({tag, " hit_count"}, hit_count, 0);
    chk({tag, " overflow"}, overflow, 0);
  endtask

  initial begin
    int e2[3] = '{3, 6, 9};
    rst = 1; hit = 0; clr = 0; rd_en = 0; h4 = 0; r4 = 0; c4 = 0;
    #1 rst = 0;
    step();
    chk_reset_vals("reset");
    rst = 1;
    // single hit at ts=5, read at ts=9
    at(5); hit = 1; step(); hit = 0;
    chk("t1 level", level, 1);
    at(9); rd_en = 1; step(); rd_en = 0;
    chk("t1 rd_data", rd_data, 5);
    chk("t1 rd_valid", rd_valid, 1);
    chk("t1 empty", empty, 1);
    step();
    chk("t1 rd_valid pulse", rd_valid, 0);
    // hits at 3,6,9 then three reads
    do_reset();
    at(3); hit = 1; step(); hit = 0; chk("t2 level1", level, 1);
    at(6); hit = 1; step(); hit = 0; chk("t2 level2", level, 2);
    at(9); hit = 1; step(); hit = 0; chk("t2 level3", level, 3);
    rd_en = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2 rd_data", rd_data, e2[i]);
      chk("t2 level down", level, 2 - i);
    end
    rd_en = 0;
    chk("t2 hit_count", hit_count, 3);
    // ten hits from ts=20 into an 8-deep FIFO
    do_reset();
    at(20); hit = 1; repeat (10) step(); hit = 0;
    chk("t3 full", full, 1);
    chk("t3 level", level, 8);
    chk("t3 overflow", overflow, 1);
    chk("t3 hit_count", hit_count, 10);
    rd_en = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t3 rd_data", rd_data, 20 + i);
    end
    rd_en = 0; step();
    chk("t3 empty", empty, 1);
    // full FIFO with simultaneous hit and read
    do_reset();
    at(20); hit = 1; repeat (8) step();
    chk("t4 full", full, 1);
    chk("t4 overflow pre", overflow, 0);
    rd_en = 1; step(); hit = 0; rd_en = 0;
    chk("t4 rd_data", rd_data, 20);
    chk("t4 rd_valid", rd_valid, 1);
    chk("t4 level", level, 8);
    chk("t4 overflow", overflow, 0);
    rd_en = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t4 drain", rd_data, 21 + i);
    end
    rd_en = 0;
    // read while empty, then 4-bit timestamp wrap
    do_reset();
    rd_en = 1; step(); rd_en = 0;
    chk("t5 empty rd_valid", rd_valid, 0);
    chk("t5 empty level", level, 0);
    at(15); h4 = 1; step(); step(); h4 = 0;
    chk("t5 w4 level", lv4, 2);
    r4 = 1; step();
    chk("t5 w4 rd 15", d4, 15);
    chk("t5 w4 valid", v4, 1);
    step(); r4 = 0;
    chk("t5 w4 rd 0", d4, 0);
    // clear with hit and read on the same edge
    do_reset();
    hit = 1; repeat (9) step(); hit = 0;
    rd_en = 1; repeat (5) step(); rd_en = 0;
    chk("t6 level", level, 3);
    chk("t6 overflow", overflow, 1);
    chk("t6 rd_data", rd_data, 4);
    clr = 1; hit = 1; rd_en = 1; step(); clr = 0; hit = 0; rd_en = 0;
    chk("t6 clr level", level, 0);
    chk("t6 clr empty", empty, 1);
    chk("t6 clr hit_count", hit_count, 0);
    chk("t6 clr overflow", overflow, 0);
    chk("t6 clr rd_valid", rd_valid, 0);
    chk("t6 clr rd_data", rd_data, 4);
    hit = 1; step(); hit = 0; rd_en = 1; step(); rd_en = 0;
    chk("t6 ts kept", rd_data, 15);
    // asynchronous reset mid-stream
    hit = 1; repeat (3) step(); hit = 0;
    @(posedge clk); #2 rst = 0; #1;
    chk_reset_vals("async rst");
    chk("async rst w4 level", lv4, 0);
    step(); rst = 1; step();
    chk("post rst empty", empty, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
